tdc_result_capture: RTL and testbench
=====================================

// Module: tdc_result_capture
// PURPOSE
//  Downstream stage of the TDC controller. It consumes the controller's clear/running/ready
//  strobes and counts coarse clock periods while a conversion runs. At the end of a conversion
//  it captures the coarse count together with the delay-line fine code into a small result FIFO.
//  Results are presented to the readout logic over a valid/ack handshake.
// PARAMETERS
//  CNT_W   8  coarse counter width (bits)
//  FINE_W  8  delay-line thermometer width
//  DEPTH   4  result FIFO entries; power of 2, >=2
//  Derived: FC_W = $clog2(FINE_W+1); WORD_W = 1 + CNT_W + FC_W
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  clear       in   1       controller clear: zero coarse counter and overflow flag
//  running     in   1       controller running: coarse counter enable
//  ctrl_ready  in   1       controller ready; rising edge = conversion done
//  fine_therm  in   FINE_W  delay-line thermometer snapshot, stable while ctrl_ready=1
//  out_data    out  WORD_W  {ovf, coarse[CNT_W-1:0], fine[FC_W-1:0]} of FIFO head
//  out_valid   out  1       FIFO non-empty
//  out_ack     in   1       consumer accepts the head entry when out_valid=1
//  drop        out  1       sticky: a capture was lost because the FIFO was full
//  count       out  CNT_W   live coarse counter (debug)
// BEHAVIOUR
//  Reset: count=0, ovf=0, FIFO empty, out_valid=0, out_data=0, drop=0, rdy_q=1.
//   rdy_q=1 suppresses a false capture if ctrl_ready is already high when reset releases.
//  Coarse counter priority per edge: clear > running > hold.
//   clear=1   -> count<=0, ovf<=0, regardless of running.
//   running=1 -> count<=count+1. At count==2^CNT_W-1: wrap to 0 and set ovf<=1 (sticky until
//                clear/rst). Macro variant below.
//  Capture event: cap = ctrl_ready & ~rdy_q; rdy_q <= ctrl_ready every cycle.
//   On cap, the word {ovf, count, fine} is pushed at the same edge. It uses register values
//   from before that edge, so a clear or increment on the same edge is not seen in the word.
//   fine = popcount(fine_therm), range 0..FINE_W. Popcount tolerates thermometer bubbles.
//  FIFO behaviour: first-word-fall-through, registered pointers plus a count.
//   push on cap at edge k into an empty FIFO -> out_valid=1 and out_data valid after edge k
//   (latency 1 from ctrl_ready rise).
//   pop = out_valid & out_ack; the head advances at that edge.
//   out_data changes only on pop or on a push into an empty FIFO.
//   Full and pop in the same cycle: pop first, push accepted, no drop.
//   Full and no pop: the word is discarded, drop<=1. drop is cleared only by rst.
//   Empty and out_ack=1: ignored.
//   Full and empty are derived from an occupancy counter of width $clog2(DEPTH)+1.
//   Pointers wrap modulo DEPTH.
//  Reset mid-operation: all state returns to the reset values in one cycle and FIFO contents
//   are lost. clear does not affect the FIFO or drop.
//  No combinational path from inputs to outputs; all outputs are registered or taken from the
//   FIFO array head.
// CONFIGURATION
//  TDC_SATURATE_EN defined: the counter holds at 2^CNT_W-1 instead of wrapping, and ovf is set
//   on the first attempted increment past max.
//  TDC_SATURATE_EN undefined: the counter wraps to 0 and ovf is set (default).
//  Port list and word format are identical in both builds.
// TESTING (CNT_W=8, FINE_W=8, DEPTH=4)
//  1. rst; clear 1 cycle; running for 5 cycles; ctrl_ready rise with fine_therm=8'h1F
//     -> next cycle out_valid=1, out_data={0,8'd5,4'd5}.
//  2. running held for 300 cycles, then capture -> wrap build: out_data={1,8'd44,fine};
//     TDC_SATURATE_EN build: out_data={1,8'd255,fine}.
//  3. 5 captures with out_ack=0 -> 4 entries held, drop=1. Pop 4 with out_ack=1
//     -> data returned in order, out_valid=0 after the 4th pop.
//  4. FIFO full, capture and out_ack=1 on the same cycle -> no drop, occupancy stays 4.
//  5. ctrl_ready=1 while rst=1, release rst -> no capture; clear on the same cycle as a capture
//     edge -> the word holds the pre-clear count, and count=0 afterwards.
//  6. fine_therm=8'b1011_0111 (bubble) -> fine field = 6.

Source files
------------

// File: rtl/tdc_result_capture.sv
// TDC result capture: coarse period counter, popcount fine code, FWFT result FIFO with sticky drop.
// Build option: TDC_SATURATE_EN makes the coarse counter saturate at max instead of wrapping.
module tdc_result_capture #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned FINE_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned FC_W   = $clog2(FINE_W + 1),
  localparam int unsigned WORD_W = 1 + CNT_W + FC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              running,
  input  logic              ctrl_ready,
  input  logic [FINE_W-1:0] fine_therm,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              drop,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rdy_q;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [FC_W-1:0]   fine_c;
  logic [WORD_W-1:0] cap_word_c;
  logic              cap_c, pop_c, full_c, push_c;

  // Popcount rather than priority-encode so delay-line bubbles still give a sane code.
  always_comb begin
    fine_c = '0;
    for (int i = 0; i < FINE_W; i++) begin
      fine_c = fine_c + FC_W'(fine_therm[i]);
    end
  end

  always_comb begin
    cap_c      = ctrl_ready & ~rdy_q;
    cap_word_c = {ovf_q, count_q, fine_c};
    pop_c      = (occ_q != '0) & out_ack;
    full_c     = (occ_q == OW'(DEPTH));
    push_c     = cap_c & (~full_c | pop_c);
  end

  // Next-state for counter and FIFO bookkeeping.
  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;

    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (running) begin
`ifdef TDC_SATURATE_EN
      if (count_q == CNT_MAX) ovf_d = 1'b1;
      else                    count_d = count_q + CNT_W'(1);
`else
      count_d = count_q + CNT_W'(1);
      if (count_q == CNT_MAX) ovf_d = 1'b1;
`endif
    end

    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (cap_c & full_c & ~pop_c) drop_d = 1'b1;
    occ_d   = occ_q + OW'(push_c) - OW'(pop_c);
    valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdy_q    <= 1'b1;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdy_q    <= ctrl_ready;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is zeroed on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= cap_word_c;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = valid_q;
  assign drop      = drop_q;
  assign count     = count_q;

endmodule

// File: tb/tb_tdc_result_capture.sv
// Self-checking bench for tdc_result_capture: directed scenarios plus random traffic vs a queue model.
// Honours TDC_SATURATE_EN the same way the design does.
module tb_tdc_result_capture;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FINE_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WORD_W = 13;

  logic              clk = 1'b0;
  logic              rst, clear, running, ctrl_ready, out_ack;
  logic [FINE_W-1:0] fine_therm;
  logic [WORD_W-1:0] out_data;
  logic              out_valid, drop;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference state
  int                m_count;
  bit                m_ovf, m_rdy, m_drop;
  logic [WORD_W-1:0] m_q[$];

  tdc_result_capture #(.CNT_W(CNT_W), .FINE_W(FINE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .running(running), .ctrl_ready(ctrl_ready),
    .fine_therm(fine_therm), .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .drop(drop), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the model, using the inputs that the DUT sampled at the same edge.
  task automatic model_edge();
    bit cap, pop;
    logic [WORD_W-1:0] w;
    if (rst) begin
      m_count = 0; m_ovf = 0; m_rdy = 1; m_drop = 0;
      m_q.delete();
      return;
    end
    cap = ctrl_ready && !m_rdy;
    w   = {m_ovf, 8'(m_count), 4'($countones(fine_therm))};
    pop = (m_q.size() > 0) && out_ack;
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else                    m_drop = 1;
    end
    if (clear) begin
      m_count = 0; m_ovf = 0;
    end else if (running) begin
`ifdef TDC_SATURATE_EN
      if (m_count == 255) m_ovf = 1;
      else                m_count = m_count + 1;
`else
      m_count = m_count + 1;
      if (m_count == 256) begin m_count = 0; m_ovf = 1; end
`endif
    end
    m_rdy = ctrl_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("drop", 32'(drop), 32'(m_drop));
    if (m_q.size() > 0) chk("data", 32'(out_data), 32'(m_q[0]));
  endtask

  task automatic idle();
    clear = 0; running = 0; ctrl_ready = 0; out_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // Rising edge of ctrl_ready for one cycle, then low again.
  task automatic capture(input logic [FINE_W-1:0] f);
    fine_therm = f; ctrl_ready = 1; tick();
    ctrl_ready = 0; tick();
  endtask

  initial begin
    rst = 1; idle(); fine_therm = '0;
    m_count = 0; m_ovf = 0; m_rdy = 1; m_drop = 0;
    tick(); tick();
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    rst = 0;

    // 1: five running cycles then capture
    clear = 1; tick(); clear = 0;
    running = 1; repeat (5) tick(); running = 0;
    fine_therm = 8'h1F; ctrl_ready = 1; tick();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'({1'b0, 8'd5, 4'd5}));
    ctrl_ready = 0; out_ack = 1; tick(); out_ack = 0;

    // 2: long run past the counter range
    clear = 1; tick(); clear = 0;
    running = 1; repeat (300) tick(); running = 0;
    capture(8'h03);
`ifdef TDC_SATURATE_EN
    chk("t2_data", 32'(out_data), 32'({1'b1, 8'd255, 4'd2}));
`else
    chk("t2_data", 32'(out_data), 32'({1'b1, 8'd44, 4'd2}));
`endif
    out_ack = 1; tick(); out_ack = 0;

    // 3: overfill, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      running = 1; tick(); running = 0;
      capture(8'(i * 3 + 1));
    end
    chk("t3_drop", 32'(drop), 32'h1);
    chk("t3_valid", 32'(out_valid), 32'h1);
    out_ack = 1;
    repeat (4) tick();
    out_ack = 0;
    chk("t3_empty", 32'(out_valid), 32'h0);

    // 4: capture while full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 4; i++) capture(8'hFF);
    running = 1; repeat (7) tick(); running = 0;
    fine_therm = 8'h01; ctrl_ready = 1; out_ack = 1; tick();
    ctrl_ready = 0; out_ack = 0; tick();
    chk("t4_drop", 32'(drop), 32'h0);
    out_ack = 1;
    repeat (4) tick();
    chk("t4_last", 32'(out_valid), 32'h0);
    out_ack = 0;

    // 5: ready high across reset release; clear coinciding with a capture
    ctrl_ready = 1; rst = 1; tick(); tick(); rst = 0;
    repeat (3) tick();
    chk("t5_nocap", 32'(out_valid), 32'h0);
    ctrl_ready = 0; running = 1; repeat (9) tick(); running = 0;
    fine_therm = 8'h00; ctrl_ready = 1; clear = 1; tick();
    clear = 0; ctrl_ready = 0;
    chk("t5_word", 32'(out_data), 32'({1'b0, 8'd9, 4'd0}));
    chk("t5_count", 32'(count), 32'h0);
    out_ack = 1; tick(); out_ack = 0;

    // 6: thermometer with a bubble
    capture(8'b1011_0111);
    chk("t6_fine", 32'(out_data[3:0]), 32'd6);
    out_ack = 1; tick(); out_ack = 0;

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 399) == 0);
      clear   = ($urandom_range(0, 199) == 0);
      running = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) ctrl_ready = ~ctrl_ready;
      if (!ctrl_ready) fine_therm = 8'($urandom);
      out_ack = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
